bcd_counter_7seg_ndisplays: RTL

Parametrised N-digit BCD up/down counter with a registered 7-segment decode per digit, for the DE-series board's hex displays. An internal prescaler generates the count tick from the system clock. Lamp test (seg7all_on), synchronous parallel load and a wrap pulse are included. Generalises the fixed 8-display decoder to any digit count, count direction and segment polarity.

---
 rtl/bcd7seg_pkg.sv | 37 +++
 rtl/bcd_digit_counter.sv | 43 ++++
 rtl/bcd_counter_7seg_ndisplays.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd7seg_pkg.sv
// rtl/bcd7seg_pkg.sv - active-high 7-segment patterns (bit order g..a) and BCD decode
package bcd7seg_pkg;

  localparam logic [3:0] BCD_MAX     = 4'd9;

  localparam logic [6:0] SEG_0       = 7'b0111111;
  localparam logic [6:0] SEG_1       = 7'b0000110;
  localparam logic [6:0] SEG_2       = 7'b1011011;
  localparam logic [6:0] SEG_3       = 7'b1001111;
  localparam logic [6:0] SEG_4       = 7'b1100110;
  localparam logic [6:0] SEG_5       = 7'b1101101;
  localparam logic [6:0] SEG_6       = 7'b1111101;
  localparam logic [6:0] SEG_7       = 7'b0000111;
  localparam logic [6:0] SEG_8       = 7'b1111111;
  localparam logic [6:0] SEG_9       = 7'b1101111;
  localparam logic [6:0] SEG_ALL_ON  = 7'b1111111;
  localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ALL_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one decade of the BCD up/down counter with ripple carry/borrow
module bcd_digit_counter
  import bcd7seg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_q, value_d;

  // carry_out means "this decade wraps if it steps"; the top qualifies it with step
  assign carry_out = carry_in && (up ? (value_q == BCD_MAX) : (value_q == 4'd0));
  assign value     = value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_value > BCD_MAX) ? 4'd0 : load_value;
    end else if (step && carry_in) begin
      if (up) begin
        value_d = (value_q >= BCD_MAX) ? 4'd0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/bcd_counter_7seg_ndisplays.sv
// rtl/bcd_counter_7seg_ndisplays.sv - N-digit BCD up/down counter with prescaler and registered 7-seg decode
// Optional: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_counter_7seg_ndisplays
  import bcd7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    seg7all_on,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic [7*NUM_DIGITS-1:0] sg7_hex,
  output logic                    tick,
  output logic                    carry_out
);

  localparam int                 PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [6:0]         SEG_POL   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    tick_q, tick_d;
  logic                    carry_q, carry_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    step;
  logic [NUM_DIGITS:0]     carry_chain;
  logic [3:0]              digit_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg_pat;

  assign step           = tick_q && enable && !load;
  assign carry_chain[0] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_counter u_digit (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_value (load_value[4*k +: 4]),
      .step       (step),
      .up         (up_down),
      .carry_in   (carry_chain[k]),
      .value      (digit_val[k]),
      .carry_out  (carry_chain[k+1])
    );
    assign bcd_value[4*k +: 4] = digit_val[k];
  end

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (load) begin
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    carry_d = step && carry_chain[NUM_DIGITS];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_zero;

  // walk down from the top digit; digit 0 is never blanked
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      higher_zero = higher_zero && (digit_val[k] == 4'd0);
      blank[k]    = higher_zero;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_d   = '0;
    seg_pat = SEG_ALL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (seg7all_on) begin
        seg_pat = SEG_ALL_ON;
      end else if (blank[k]) begin
        seg_pat = SEG_ALL_OFF;
      end else begin
        seg_pat = bcd_to_seg(digit_val[k]);
      end
      seg_d[7*k +: 7] = seg_pat ^ SEG_POL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_0 ^ SEG_POL}};
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
    end
  end

  assign sg7_hex   = seg_q;
  assign tick      = tick_q;
  assign carry_out = carry_q;

endmodule
